neuron_acc18: RTL and testbench
===============================

NEURON_ACC18 -- requirements
Module: neuron_acc18

Interface
REQ-001 Parameter DW, default 18: signed input/output sample width.
REQ-002 Parameter ACC_W, default 24: signed accumulator width.
REQ-003 Parameter MAX_TERMS, default 64: maximum terms per frame; 2^(DW-1) * MAX_TERMS SHALL fit in ACC_W signed bits.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 in_valid  input  1  upstream term valid.
REQ-007 in_ready  output  1  block accepts a term this cycle.
REQ-008 in_data  input  DW  signed term, e.g. an 18-bit adder-stage sum narrowed to DW.
REQ-009 in_last  input  1  marks the final term of a frame.
REQ-010 out_valid  output  1  result valid.
REQ-011 out_ready  input  1  downstream accepts the result.
REQ-012 out_data  output  DW  signed result, saturated to DW bits.
REQ-013 out_sat  output  1  out_data was clamped.
REQ-014 out_trunc  output  1  frame was force-closed at MAX_TERMS without in_last.

Function
REQ-015 A term SHALL be accepted only when in_valid and in_ready are both 1 in the same cycle.
REQ-016 The FSM SHALL have two states, ACC and HOLD, and SHALL reset to ACC.
REQ-017 ACC: in_ready=1, out_valid=0; each accepted term SHALL be sign-extended to ACC_W bits and added to acc; cnt SHALL increment.
REQ-018 ACC to HOLD: on accepting a term with in_last=1, or on accepting the MAX_TERMS-th term (cnt==MAX_TERMS-1); the final term SHALL be included in the result.
REQ-019 The result SHALL be registered on the transition: out_valid=1 exactly one cycle after the final term is accepted (latency 1).
REQ-020 out_data SHALL equal acc+term clamped to [-2^(DW-1), 2^(DW-1)-1] (-131072..131071 by default); out_sat=1 iff clamping occurred.
REQ-021 out_trunc SHALL be 1 iff the frame closed on the MAX_TERMS count with in_last=0.
REQ-022 HOLD: in_ready=0; out_valid=1; out_data, out_sat and out_trunc SHALL stay stable until out_ready=1.
REQ-023 HOLD to ACC: on out_valid and out_ready both 1; acc and cnt SHALL clear in the same cycle; a new term SHALL be accepted no earlier than the following cycle.
REQ-024 A term with in_last=1 accepted as the very first term SHALL produce a one-term result equal to in_data, with no saturation.
REQ-025 in_valid=0 in ACC SHALL hold acc and cnt unchanged; in_data and in_last are ignored while in_valid=0.
REQ-026 The accumulator SHALL never wrap, guaranteed by REQ-003; no additional overflow logic is required.

Reset
REQ-027 On rst=1, asynchronously: state=ACC, acc=0, cnt=0, out_valid=0, out_data=0, out_sat=0, out_trunc=0; in_ready=1 after reset.
REQ-028 Reset mid-frame or in HOLD SHALL discard the partial sum or pending result; no result SHALL be emitted for that frame.

Structure
REQ-029 DW, ACC_W, MAX_TERMS defaults and the saturation limits SHALL be defined in the shared package ann_pkg, alongside the FSM state enum (ACC, HOLD).
REQ-030 Saturation SHALL be a combinational sub-module sat_narrow (ACC_W in, DW out plus sat flag) so adder/MAC stages can reuse it.
REQ-031 The top SHALL contain only the FSM, acc register, cnt register and output registers.

Verification
REQ-032 Terms 100, -30, 5 (last on 5), out_ready=1 -> out_data=75, out_sat=0, out_trunc=0, out_valid one cycle after the third term is accepted.
REQ-033 Two terms of 131071 (last on 2nd) -> out_data=131071, out_sat=1; two terms of -131072 -> out_data=-131072, out_sat=1.
REQ-034 64 terms of 1 with in_last=0 throughout -> out_data=64, out_trunc=1, in_ready=0 in the cycle after the 64th accept.
REQ-035 Hold out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0 and out_data stable throughout; no terms accepted; the next frame's acc starts from 0.
REQ-036 Assert rst for 1 cycle after 3 of 5 terms -> all outputs 0 immediately; a following 2-term frame (7, 8) -> out_data=15.
REQ-037 Single term -5 with in_last=1 -> out_data=-5, out_sat=0, out_trunc=0.

Source files
------------

// File: rtl/ann_pkg.sv
// ann_pkg -- shared definitions for the neuron datapath blocks.
//
// Holds the default widths and frame length used by the accumulator,
// the default saturation limits for a DW-bit signed result, and the
// two-state accumulator FSM encoding. Adder/MAC stages import the same
// package so every stage agrees on widths and clamp limits.
package ann_pkg;

  // Default signed sample width (input terms and narrowed result).
  localparam int DW_DEF        = 18;
  // Default signed accumulator width.
  localparam int ACC_W_DEF     = 24;
  // Default maximum number of terms in one frame.
  // (2^(DW-1)) * MAX_TERMS must fit in ACC_W signed bits so the
  // accumulator can never wrap: 2^17 * 64 = 2^23 fits in 24 signed bits.
  localparam int MAX_TERMS_DEF = 64;

  // Saturation limits for the default DW.
  localparam int SAT_MAX = (1 << (DW_DEF - 1)) - 1;  //  131071
  localparam int SAT_MIN = -(1 << (DW_DEF - 1));     // -131072

  // Accumulator FSM: ACC gathers terms, HOLD presents the result.
  typedef enum logic [0:0] {
    ACC  = 1'b0,
    HOLD = 1'b1
  } acc_state_t;

endpackage : ann_pkg

// File: rtl/sat_narrow.sv
// sat_narrow -- combinational signed narrowing with saturation.
//
// Clamps a signed ACC_W-bit value into the signed DW-bit range
// [-2^(DW-1), 2^(DW-1)-1] and flags when clamping occurred. Purely
// combinational so it can sit behind any adder or MAC stage.
//
// Ports:
//   din   in   ACC_W  signed wide value
//   dout  out  DW     signed narrowed (possibly clamped) value
//   sat   out  1      1 when din was outside the DW range
module sat_narrow #(
  parameter int ACC_W = 24,
  parameter int DW    = 18
) (
  input  logic signed [ACC_W-1:0] din,
  output logic signed [DW-1:0]    dout,
  output logic                    sat
);

  // Range limits expressed at the wide width so comparisons stay signed.
  localparam logic signed [ACC_W-1:0] HI =
    {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] LO =
    {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};

  typedef struct packed {
    logic signed [DW-1:0] val;
    logic                 sat;
  } sat_res_t;

  function automatic sat_res_t sat_clamp(input logic signed [ACC_W-1:0] x);
    sat_res_t r;
    if (x > HI) begin
      r.val = HI[DW-1:0];
      r.sat = 1'b1;
    end else if (x < LO) begin
      r.val = LO[DW-1:0];
      r.sat = 1'b1;
    end else begin
      r.val = x[DW-1:0];
      r.sat = 1'b0;
    end
    return r;
  endfunction

  sat_res_t res;

  always_comb begin
    res  = sat_clamp(din);
    dout = res.val;
    sat  = res.sat;
  end

endmodule : sat_narrow

// File: rtl/neuron_acc18.sv
// neuron_acc18 -- framed signed accumulator with saturated result.
//
// Sums a frame of signed DW-bit terms into an ACC_W-bit accumulator.
// A frame ends on a term marked in_last, or is force-closed when the
// MAX_TERMS-th term is accepted. The closing term is folded into the
// result, which is narrowed with saturation and held on the output
// (valid/ready) until the consumer takes it. Input is stalled while a
// result is held.
//
// Ports:
//   clk        in   1      clock, rising edge
//   rst        in   1      asynchronous active-high reset
//   in_valid   in   1      upstream term valid
//   in_ready   out  1      term accepted this cycle when in_valid=1
//   in_data    in   DW     signed term
//   in_last    in   1      final term of the frame
//   out_valid  out  1      result valid
//   out_ready  in   1      downstream takes the result
//   out_data   out  DW     signed result, saturated to DW bits
//   out_sat    out  1      out_data was clamped
//   out_trunc  out  1      frame closed at MAX_TERMS without in_last
module neuron_acc18
  import ann_pkg::*;
#(
  parameter int DW        = DW_DEF,
  parameter int ACC_W     = ACC_W_DEF,
  parameter int MAX_TERMS = MAX_TERMS_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] in_data,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [DW-1:0] out_data,
  output logic                 out_sat,
  output logic                 out_trunc
);

  localparam int CNT_W = (MAX_TERMS > 1) ? $clog2(MAX_TERMS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_TERMS - 1);

  acc_state_t               state;
  logic signed [ACC_W-1:0]  acc;
  logic        [CNT_W-1:0]  cnt;

  logic signed [ACC_W-1:0]  term_ext;
  logic signed [ACC_W-1:0]  acc_sum;
  logic signed [DW-1:0]     sat_data;
  logic                     sat_flag;
  logic                     accept;
  logic                     cnt_full;
  logic                     close;

  // Sum including the current term; this is both the next accumulator
  // value and, on the closing term, the value that gets narrowed.
  always_comb begin
    term_ext = {{(ACC_W-DW){in_data[DW-1]}}, in_data};
    acc_sum  = acc + term_ext;
  end

  sat_narrow #(
    .ACC_W (ACC_W),
    .DW    (DW)
  ) u_sat (
    .din  (acc_sum),
    .dout (sat_data),
    .sat  (sat_flag)
  );

  assign in_ready = (state == ACC);
  assign accept   = in_valid & in_ready;
  assign cnt_full = (cnt == CNT_LAST);
  assign close    = accept & (in_last | cnt_full);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ACC;
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
      out_trunc <= 1'b0;
    end else begin
      case (state)
        ACC: begin
          if (close) begin
            // Result is captured here so it appears one cycle after the
            // closing term; acc/cnt are cleared on the way out of HOLD.
            state     <= HOLD;
            out_valid <= 1'b1;
            out_data  <= sat_data;
            out_sat   <= sat_flag;
            out_trunc <= ~in_last;
          end else if (accept) begin
            acc <= acc_sum;
            cnt <= cnt + CNT_W'(1);
          end
        end
        HOLD: begin
          if (out_ready) begin
            state     <= ACC;
            out_valid <= 1'b0;
            acc       <= '0;
            cnt       <= '0;
          end
        end
        default: begin
          state <= ACC;
        end
      endcase
    end
  end

endmodule : neuron_acc18

// File: tb/tb_neuron_acc18.sv
// tb_neuron_acc18 -- directed bench for neuron_acc18 with hand-computed
// expected results.
module tb_neuron_acc18;

  logic               clk;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic signed [17:0] in_data;
  logic               in_last;
  logic               out_valid;
  logic               out_ready;
  logic signed [17:0] out_data;
  logic               out_sat;
  logic               out_trunc;

  int errs;
  int checks;

  neuron_acc18 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .out_trunc (out_trunc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Present one term from a falling edge; it is taken at the next rising
  // edge where in_ready is high. Returns #1 after the accepting edge.
  task automatic push(input int d, input logic last);
    int guard;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 18'(d);
    in_last  = last;
    guard    = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      chk("push_timeout", 0, 1);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 18'sh2AAAA;
  endtask

  // Check the held result, then hand it off and confirm the return to ACC.
  task automatic pop(input string tag, input int d, input int sat, input int trunc);
    chk({tag, "_valid"}, int'(out_valid), 1);
    chk({tag, "_data"}, int'(out_data), d);
    chk({tag, "_sat"}, int'(out_sat), sat);
    chk({tag, "_trunc"}, int'(out_trunc), trunc);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, "_released"}, int'(out_valid), 0);
    chk({tag, "_ready_back"}, int'(in_ready), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    errs      = 0;
    checks    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_data", int'(out_data), 0);
    chk("rst_sat", int'(out_sat), 0);
    chk("rst_trunc", int'(out_trunc), 0);
    chk("rst_ready", int'(in_ready), 1);
    @(negedge clk);
    rst = 1'b0;

    // 100 - 30 + 5 = 75; result one cycle after the third accept.
    push(100, 1'b0);
    push(-30, 1'b0);
    chk("f1_no_early_valid", int'(out_valid), 0);
    push(5, 1'b1);
    chk("f1_ready_low", int'(in_ready), 0);
    pop("f1", 75, 0, 0);

    // Positive and negative clamping.
    push(131071, 1'b0);
    push(131071, 1'b1);
    pop("satp", 131071, 1, 0);
    push(-131072, 1'b0);
    push(-131072, 1'b1);
    pop("satn", -131072, 1, 0);

    // Exact top of range is not saturated.
    push(131070, 1'b0);
    push(1, 1'b1);
    pop("edge", 131071, 0, 0);

    // 64 ones without in_last: forced close, truncation flagged.
    for (int i = 0; i < 63; i++) push(1, 1'b0);
    chk("trunc_63_not_done", int'(out_valid), 0);
    push(1, 1'b0);
    chk("trunc_ready_low", int'(in_ready), 0);
    pop("trunc", 64, 0, 1);

    // Back-pressure: result held while in_valid stays high.
    push(10, 1'b0);
    push(20, 1'b1);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 18'sd999;
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("bp_ready", int'(in_ready), 0);
      chk("bp_data", int'(out_data), 30);
      chk("bp_valid", int'(out_valid), 1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    pop("bp", 30, 0, 0);
    push(4, 1'b1);
    pop("bp_next", 4, 0, 0);

    // Reset mid-frame discards the partial sum immediately.
    push(1, 1'b0);
    push(2, 1'b0);
    push(3, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", int'(out_valid), 0);
    chk("mid_rst_data", int'(out_data), 0);
    chk("mid_rst_ready", int'(in_ready), 1);
    @(negedge clk);
    rst = 1'b0;
    push(7, 1'b0);
    push(8, 1'b1);
    pop("post_rst", 15, 0, 0);

    // Reset while holding a result drops it.
    push(9, 1'b1);
    chk("hold_pre_valid", int'(out_valid), 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("hold_rst_valid", int'(out_valid), 0);
    chk("hold_rst_data", int'(out_data), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("hold_rst_stays", int'(out_valid), 0);

    // One-term frame.
    push(-5, 1'b1);
    pop("single", -5, 0, 0);

    // Idle cycles with in_valid low leave the sum untouched.
    push(3, 1'b0);
    @(negedge clk);
    in_data = 18'sd500;
    in_last = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_no_valid", int'(out_valid), 0);
    push(4, 1'b1);
    pop("idle", 7, 0, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule : tb_neuron_acc18
